// File: rtl/taylor_result_collector_if.sv
// Result stream from the collector toward the host interface.
// The master drives a show-ahead head entry; the slave accepts it with m_ready.
interface taylor_result_collector_if #(
  parameter int DW = 28,
  parameter int IW = 5
);
  logic signed [DW-1:0] m_data;
  logic [IW-1:0]        m_idx;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_idx, output m_valid, input m_ready);
  modport slave  (input m_data, input m_idx, input m_valid, output m_ready);
endinterface

// File: rtl/taylor_result_collector.sv
// Collects results from an array of rede_taylor cores: per-core holding slots,
// round-robin arbitration into a tagged FIFO, and lossless-or-counted delivery.
module taylor_result_collector #(
  parameter int NCORES     = 27,
  parameter int DW         = 28,
  parameter int EW         = 4,
  parameter int VALID_CODE = 1,
  parameter int EDGE       = 1,
  parameter int DEPTH      = 32,
  parameter int IW         = 5,
  localparam int AW        = $clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCORES*DW-1:0]   io_out_bus,
  input  logic [NCORES*EW-1:0]   out_en_bus,
  taylor_result_collector_if.master m_if,
  output logic [LW-1:0]          fifo_level,
  output logic [15:0]            res_cnt,
  output logic [15:0]            drop_cnt,
  output logic                   overrun
);

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } entry_t;

  // Input register stage: the wide core bus is retimed before any decision is made.
  logic [NCORES-1:0] valid_in_q, valid_prev_q;
  logic [DW-1:0]     din_q [NCORES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_in_q   <= '0;
      valid_prev_q <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++)
        valid_in_q[i] <= (out_en_bus[i*EW +: EW] == EW'(VALID_CODE));
      valid_prev_q <= valid_in_q;
    end
  end

  // NOTE: pure datapath/storage arrays carry no reset; the flags that qualify them do.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCORES; i++)
      din_q[i] <= io_out_bus[i*DW +: DW];
  end

  logic [NCORES-1:0] pending_q, pending_d, hit, capture, drop, grant_oh;
  logic [DW-1:0]     slot_q [NCORES];
  logic [IW-1:0]     rr_q, grant_idx;
  logic [IW:0]       cand, n_drop;
  logic              grant_vld, full, empty, push, pop;

  // Round-robin search: first pending slot at or after the pointer, wrapping at NCORES.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!full) begin
      for (int k = 0; k < NCORES; k++) begin
        cand = {1'b0, rr_q} + (IW+1)'(k);
        if (cand >= (IW+1)'(NCORES)) cand = cand - (IW+1)'(NCORES);
        if (!grant_vld && pending_q[cand[IW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[IW-1:0];
        end
      end
    end
  end

  // A granted slot frees up in the same cycle, so a fresh hit on it is not a loss.
  always_comb begin
    hit       = '0;
    capture   = '0;
    drop      = '0;
    grant_oh  = '0;
    pending_d = pending_q;
    n_drop    = '0;
    for (int i = 0; i < NCORES; i++) begin
      hit[i]       = valid_in_q[i] && ((EDGE == 0) || !valid_prev_q[i]);
      grant_oh[i]  = grant_vld && (grant_idx == IW'(i));
      capture[i]   = hit[i] && (!pending_q[i] || grant_oh[i]);
      drop[i]      = hit[i] && pending_q[i] && !grant_oh[i];
      pending_d[i] = capture[i] || (pending_q[i] && !grant_oh[i]);
      n_drop       = n_drop + (IW+1)'(drop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCORES; i++)
      if (capture[i]) slot_q[i] <= din_q[i];
  end

  // FIFO storage and show-ahead head.
  entry_t          mem [DEPTH];
  entry_t          wr_entry, head, last_q;
  logic [AW-1:0]   wr_q, rd_q;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     res_cnt_q, drop_cnt_q, drop_cnt_d;
  logic [16:0]     drop_sum;
  logic            overrun_q;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign push  = grant_vld;
  assign pop   = !empty && m_if.m_ready;
  assign head  = mem[rd_q];

  always_comb begin
    wr_entry      = '0;
    wr_entry.idx  = grant_idx;
    wr_entry.data = slot_q[grant_idx];
    level_d       = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    drop_sum   = {1'b0, drop_cnt_q} + 17'(n_drop);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      rr_q       <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      last_q     <= '0;
      res_cnt_q  <= '0;
      drop_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (grant_vld) begin
        rr_q      <= (grant_idx == IW'(NCORES-1)) ? '0 : grant_idx + 1'b1;
        wr_q      <= wr_q + 1'b1;
        res_cnt_q <= res_cnt_q + 1'b1;
      end
      if (pop)    rd_q   <= rd_q + 1'b1;
      if (!empty) last_q <= head;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      overrun_q  <= overrun_q || (|drop);
    end
  end

  // While empty the outputs hold the last head shown rather than stale storage.
  assign m_if.m_data  = empty ? last_q.data : head.data;
  assign m_if.m_idx   = empty ? last_q.idx  : head.idx;
  assign m_if.m_valid = !empty;
  assign fifo_level   = level_q;
  assign res_cnt      = res_cnt_q;
  assign drop_cnt     = drop_cnt_q;
  assign overrun      = overrun_q;

endmodule
